// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
//
// Receives a framed byte stream from the UART receiver, assembles 32-bit
// instruction words (MSB first), writes them into the instruction memory and
// keeps the CPU held until a complete image with a matching XOR checksum has
// been loaded.
//
// Frame: SYNC_BYTE, COUNT (N words, 0 means 256), N*4 data bytes, CHK byte
// where CHK is the XOR of all data bytes.
//
// Ports:
//   MAX10_CLK1_50  in   system clock
//   reset          in   synchronous active-high reset
//   rx_valid       in   one-cycle strobe qualifying rx_byte
//   rx_byte        in   received byte
//   imem_we        out  one-cycle instruction memory write strobe
//   imem_addr      out  write address (holds between writes)
//   imem_wdata     out  write data (holds between writes)
//   cpu_hold       out  1 = CPU held in reset, 0 = CPU runs
//   load_done      out  last frame loaded and verified
//   load_error     out  last frame failed (checksum or timeout)
//   words_loaded   out  words written in the current/last frame
// -----------------------------------------------------------------------------
module imem_uart_loader #(
  parameter int         ADDR_W         = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] n_words;
  logic [1:0]       byte_idx;
  // Only the three most recent bytes are needed: the fourth byte of a word
  // is taken straight from rx_byte when the word is written.
  logic [23:0]      asm_reg;
  logic [7:0]       checksum;
  logic [TO_W-1:0]  to_cnt;

  logic sync_seen;
  logic in_frame;
  logic timeout_hit;
  logic word_accept;
  logic last_word;

  logic enter_count;
  logic cpu_hold_d;
  logic load_done_d;
  logic load_error_d;

  assign sync_seen   = rx_valid && (rx_byte == SYNC_BYTE);
  assign in_frame    = (state == COUNT) || (state == DATA) || (state == CHECK);
  // An arriving byte on the terminal count wins over the timeout.
  assign timeout_hit = in_frame && !rx_valid &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign word_accept = (state == DATA) && rx_valid && (byte_idx == 2'd3);
  assign last_word   = ((words_loaded + CNT_W'(1)) == n_words);

  // State register
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (sync_seen) next_state = COUNT;
      end
      COUNT: begin
        if (rx_valid)         next_state = DATA;
        else if (timeout_hit) next_state = ERROR;
      end
      DATA: begin
        if (word_accept && last_word) next_state = CHECK;
        else if (timeout_hit)         next_state = ERROR;
      end
      CHECK: begin
        if (rx_valid)         next_state = (rx_byte == checksum) ? DONE : ERROR;
        else if (timeout_hit) next_state = ERROR;
      end
      DONE, ERROR: begin
        if (sync_seen) next_state = COUNT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: status flags follow the state being entered so that the
  // registered outputs change in the cycle after the transition.
  always_comb begin
    cpu_hold_d   = 1'b1;
    load_done_d  = 1'b0;
    load_error_d = 1'b0;
    case (next_state)
      DONE: begin
        cpu_hold_d  = 1'b0;
        load_done_d = 1'b1;
      end
      ERROR: begin
        load_error_d = 1'b1;
      end
      default: begin
      end
    endcase
    enter_count = (next_state == COUNT) && (state != COUNT);
  end

  // Datapath and registered outputs. The word index is the low ADDR_W bits
  // of words_loaded, so it wraps naturally for a 256-word frame.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      asm_reg      <= '0;
      checksum     <= '0;
      to_cnt       <= '0;
    end else begin
      imem_we    <= word_accept;
      cpu_hold   <= cpu_hold_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;

      if (word_accept) begin
        imem_addr  <= words_loaded[ADDR_W-1:0];
        imem_wdata <= {asm_reg, rx_byte};
      end

      if (!in_frame || rx_valid) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (enter_count) begin
        words_loaded <= '0;
        checksum     <= '0;
        byte_idx     <= '0;
      end else if ((state == COUNT) && rx_valid) begin
        n_words  <= (rx_byte == 8'd0) ? CNT_W'(256) : CNT_W'(rx_byte);
        checksum <= '0;
        byte_idx <= '0;
      end else if ((state == DATA) && rx_valid) begin
        asm_reg  <= {asm_reg[15:0], rx_byte};
        checksum <= checksum ^ rx_byte;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          words_loaded <= words_loaded + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_uart_loader
//
// Self-checking bench for imem_uart_loader. Frames are built from byte lists;
// the expected memory writes (address, word, cycle) are derived from the frame
// contents and queued as each word's last byte is issued. An independent
// monitor pops and compares on every imem_we pulse. Frame status (done,
// error, hold, word count) is checked after each frame.
// -----------------------------------------------------------------------------
module tb_imem_uart_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];

  imem_uart_loader #(
    .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one byte for one clock; returns 1 time unit after the accept edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // chk_sel: -1 correct checksum, -2 corrupted checksum, >=0 explicit byte.
  // long_gap_at: data byte index preceded by TIMEOUT-1 idle cycles, or -1.
  task automatic send_frame(input int n, input logic [7:0] dq[$],
                            input int chk_sel, input int max_gap,
                            input int long_gap_at);
    logic [7:0]  chk;
    logic [7:0]  sent;
    logic [31:0] w;
    logic [7:0]  b;
    bit          ok;
    chk = 8'h00;
    w   = 32'h0;
    applyStimulus(8'hA5);
    checkOutput("hold_after_sync", 32'(cpu_hold), 32'd1);
    checkOutput("done_after_sync", 32'(load_done), 32'd0);
    checkOutput("err_after_sync", 32'(load_error), 32'd0);
    checkOutput("words_after_sync", 32'(words_loaded), 32'd0);
    idle($urandom_range(max_gap, 0));
    applyStimulus(8'(n));
    for (int i = 0; i < n * 4; i++) begin
      if (i == long_gap_at) idle(TIMEOUT - 1);
      else idle($urandom_range(max_gap, 0));
      b   = dq[i];
      chk = chk ^ b;
      w   = {w[23:0], b};
      if ((i % 4) == 3)
        exp_q.push_back('{addr: 8'((i / 4) % 256), data: w, cyc: cyc + 1});
      applyStimulus(b);
    end
    if (chk_sel == -1)      sent = chk;
    else if (chk_sel == -2) sent = chk ^ 8'($urandom_range(255, 1));
    else                    sent = 8'(chk_sel);
    ok = (sent == chk);
    idle($urandom_range(max_gap, 0));
    applyStimulus(sent);
    idle(2);
    checkOutput("load_done", 32'(load_done), 32'(ok));
    checkOutput("load_error", 32'(load_error), 32'(!ok));
    checkOutput("cpu_hold", 32'(cpu_hold), 32'(!ok));
    checkOutput("words_loaded", 32'(words_loaded), 32'(n));
    checkOutput("addr_hold", 32'(imem_addr), 32'((n - 1) % 256));
    checkOutput("wdata_hold", imem_wdata, w);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_error", 32'(load_error), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(imem_addr), 32'(e.addr));
        checkOutput("wr_data", imem_wdata, e.data);
        checkOutput("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] dq[$];
    int n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(3);
    check_reset_values();
    reset = 1'b0;
    idle(2);

    // Bytes before a sync marker are ignored in IDLE.
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    idle(2);
    checkOutput("idle_hold", 32'(cpu_hold), 32'd1);
    checkOutput("idle_words", 32'(words_loaded), 32'd0);

    // Single word frame.
    dq = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(1, dq, 32'h22, 0, -1);

    // Two words, good checksum then bad checksum.
    dq = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_frame(2, dq, 32'h03, 1, -1);
    send_frame(2, dq, 32'h00, 1, -1);

    // N=0 means 256 words, back to back.
    dq.delete();
    for (int k = 0; k < 1024; k++) dq.push_back(8'h00);
    send_frame(0 + 256, dq, 32'h00, 0, -1);

    // Timeout mid-word: no write, error raised only after the full idle span.
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    idle(TIMEOUT - 2);
    checkOutput("no_early_timeout", 32'(load_error), 32'd0);
    idle(4);
    checkOutput("timeout_error", 32'(load_error), 32'd1);
    checkOutput("timeout_hold", 32'(cpu_hold), 32'd1);
    checkOutput("timeout_done", 32'(load_done), 32'd0);

    // Recovery; a byte arriving on the terminal count is still accepted.
    dq.delete();
    for (int k = 0; k < 8; k++) dq.push_back(8'($urandom));
    send_frame(2, dq, -1, 0, 5);

    // In-frame sync bytes are data.
    dq = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
    send_frame(1, dq, 32'h00, 0, -1);

    // Randomized frames with random gaps and occasional bad checksums.
    for (int f = 0; f < 8; f++) begin
      dq.delete();
      n = $urandom_range(8, 1);
      for (int k = 0; k < n * 4; k++) dq.push_back(8'($urandom));
      send_frame(n, dq, (($urandom % 3) == 0) ? -2 : -1, 3, -1);
    end

    // Reset in the middle of word 0 aborts the frame.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    reset = 1'b1;
    idle(1);
    check_reset_values();
    reset = 1'b0;
    idle(3);
    checkOutput("post_reset_we", 32'(imem_we), 32'd0);

    // Back in IDLE: a stray byte is ignored and a fresh frame loads.
    applyStimulus(8'h01);
    dq = {8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(1, dq, -1, 2, -1);

    idle(4);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
